// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: ALU opcodes and multiplier FSM states.
package exec_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_NOR   = 4'd5;
    localparam logic [3:0] ALU_SLL   = 4'd6;
    localparam logic [3:0] ALU_SRL   = 4'd7;
    localparam logic [3:0] ALU_SRA   = 4'd8;
    localparam logic [3:0] ALU_SLT   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;
    localparam logic [3:0] ALU_MUL   = 4'd11;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    function automatic logic is_mul_op(input logic [3:0] op);
        return op == ALU_MUL;
    endfunction

endpackage

// File: rtl/iterative_multiplier.sv
// Shift-and-add multiplier retiring BITS_PER_CYCLE bits of B per clock; holds the
// product in DONE until the downstream register accepts it.
module iterative_multiplier
    import exec_pkg::*;
#(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ack,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int ITERS = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    mul_state_t       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] w_partial;

    // r_a is pre-shifted each iteration, so the current low slice of r_b
    // always lines up with the right weight.
    assign w_partial = r_a * WIDTH'(r_b[BITS_PER_CYCLE-1:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= MUL_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                MUL_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_acc   <= '0;
                        r_count <= '0;
                        r_busy  <= 1'b1;
                        r_state <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    r_acc   <= r_acc + w_partial;
                    r_a     <= r_a << BITS_PER_CYCLE;
                    r_b     <= r_b >> BITS_PER_CYCLE;
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == LAST_ITER) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    if (ack) begin
                        r_done  <= 1'b0;
                        r_state <= MUL_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= MUL_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_acc;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: combinational ALU and branch compare, MUL through the iterative
// multiplier with upstream stall, results registered into the EX/MEM boundary.
module execute_stage
    import exec_pkg::*;
#(
    parameter int DATAPATH_WIDTH     = 64,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int INST_ADDR_WIDTH    = 9,
    parameter int THREAD_BITS        = 2,
    parameter int MUL_BITS_PER_CYCLE = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [DATAPATH_WIDTH-1:0]     R1_data_in,
    input  logic [DATAPATH_WIDTH-1:0]     R2_data_in,
    input  logic [DATAPATH_WIDTH-1:0]     store_data_in,
    input  logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_in,
    input  logic                          WR_en_in,
    input  logic                          mem_reg_sel_in,
    input  logic                          mem_write_in,
    input  logic [3:0]                    alu_ctrl_in,
    input  logic                          beq_in,
    input  logic                          bneq_in,
    input  logic [INST_ADDR_WIDTH-1:0]    branch_offset_in,
    input  logic [THREAD_BITS-1:0]        thread_id_in,
    output logic [DATAPATH_WIDTH-1:0]     alu_result_out,
    output logic [DATAPATH_WIDTH-1:0]     store_data_out,
    output logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_out,
    output logic                          WR_en_out,
    output logic                          mem_reg_sel_out,
    output logic                          mem_write_out,
    output logic [THREAD_BITS-1:0]        thread_id_out,
    output logic                          branch_taken_out,
    output logic [INST_ADDR_WIDTH-1:0]    branch_offset_out,
    output logic                          stall_out
);

    localparam int SHAMT_W = $clog2(DATAPATH_WIDTH);

    logic [SHAMT_W-1:0]        w_shamt;
    logic                      w_slt;
    logic                      w_is_mul;
    logic                      w_mul_busy;
    logic                      w_mul_done;
    logic [DATAPATH_WIDTH-1:0] w_mul_product;
    logic [DATAPATH_WIDTH-1:0] w_alu_result;
    logic                      w_operands_eq;
    logic                      w_taken;
    logic                      w_stall;

    assign w_shamt  = R2_data_in[SHAMT_W-1:0];
    assign w_slt    = $signed(R1_data_in) < $signed(R2_data_in);
    assign w_is_mul = is_mul_op(alu_ctrl_in);

    iterative_multiplier #(
        .WIDTH          (DATAPATH_WIDTH),
        .BITS_PER_CYCLE (MUL_BITS_PER_CYCLE)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (w_is_mul),
        .ack     (en),
        .a       (R1_data_in),
        .b       (R2_data_in),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

    always_comb begin
        w_alu_result = '0;
        case (alu_ctrl_in)
            ALU_ADD:   w_alu_result = R1_data_in + R2_data_in;
            ALU_SUB:   w_alu_result = R1_data_in - R2_data_in;
            ALU_AND:   w_alu_result = R1_data_in & R2_data_in;
            ALU_OR:    w_alu_result = R1_data_in | R2_data_in;
            ALU_XOR:   w_alu_result = R1_data_in ^ R2_data_in;
            ALU_NOR:   w_alu_result = ~(R1_data_in | R2_data_in);
            ALU_SLL:   w_alu_result = R1_data_in << w_shamt;
            ALU_SRL:   w_alu_result = R1_data_in >> w_shamt;
            ALU_SRA:   w_alu_result = $signed(R1_data_in) >>> w_shamt;
            ALU_SLT:   w_alu_result = {{(DATAPATH_WIDTH-1){1'b0}}, w_slt};
            ALU_PASSB: w_alu_result = R2_data_in;
            // Only reaches the output register in DONE, when the stall has dropped.
            ALU_MUL:   w_alu_result = w_mul_product;
            default:   w_alu_result = '0;
        endcase
    end

    // With both branch types set one of the two terms is always true.
    assign w_operands_eq = (R1_data_in == R2_data_in);
    assign w_taken       = (beq_in & w_operands_eq) | (bneq_in & ~w_operands_eq);

    assign w_stall   = w_mul_busy | (~w_mul_busy & ~w_mul_done & w_is_mul);
    assign stall_out = w_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_result_out    <= '0;
            store_data_out    <= '0;
            WR_addr_out       <= '0;
            WR_en_out         <= 1'b0;
            mem_reg_sel_out   <= 1'b0;
            mem_write_out     <= 1'b0;
            thread_id_out     <= '0;
            branch_taken_out  <= 1'b0;
            branch_offset_out <= '0;
        end else if (en) begin
            if (w_stall) begin
                WR_en_out        <= 1'b0;
                mem_reg_sel_out  <= 1'b0;
                mem_write_out    <= 1'b0;
                branch_taken_out <= 1'b0;
            end else begin
                alu_result_out    <= w_alu_result;
                store_data_out    <= store_data_in;
                WR_addr_out       <= WR_addr_in;
                WR_en_out         <= WR_en_in;
                mem_reg_sel_out   <= mem_reg_sel_in;
                mem_write_out     <= mem_write_in;
                thread_id_out     <= thread_id_in;
                branch_taken_out  <= w_taken;
                branch_offset_out <= branch_offset_in;
            end
        end
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the multithreaded pipeline: consumes the decode/execute pipeline register outputs, performs ALU and branch resolution, and registers the result into the execute/memory boundary. Single-cycle ops complete in one clock. MUL runs on an iterative multiplier that stalls upstream via `stall_out` and inserts bubbles downstream until the product is ready.

## Interface
- `DATAPATH_WIDTH`, 64, operand/result width.
- `REGFILE_ADDR_WIDTH`, 5, write-back register address width.
- `INST_ADDR_WIDTH`, 9, branch offset width.
- `THREAD_BITS`, 2, thread id width.
- `MUL_BITS_PER_CYCLE`, 4, multiplier bits retired per iteration; must divide `DATAPATH_WIDTH`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low; all state clears while 0.
- `en` in 1: downstream advance; the output register loads only when 1.
- `R1_data_in`, `R2_data_in` in `DATAPATH_WIDTH`: ALU operands A, B.
- `store_data_in` in `DATAPATH_WIDTH`: store data, passed through.
- `WR_addr_in` in `REGFILE_ADDR_WIDTH`; `WR_en_in`, `mem_reg_sel_in`, `mem_write_in` in 1: passed through.
- `alu_ctrl_in` in 4: opcode.
- `beq_in`, `bneq_in` in 1: branch type.
- `branch_offset_in` in `INST_ADDR_WIDTH`; `thread_id_in` in `THREAD_BITS`.
- `alu_result_out` out `DATAPATH_WIDTH`: registered result.
- `store_data_out`, `WR_addr_out`, `WR_en_out`, `mem_reg_sel_out`, `mem_write_out`, `thread_id_out` out: registered pass-through.
- `branch_taken_out` out 1, `branch_offset_out` out `INST_ADDR_WIDTH`: registered redirect for `thread_id_out`.
- `stall_out` out 1: combinational; upstream must hold its outputs while 1.

## Operation
- Opcodes, all results truncated to `DATAPATH_WIDTH`:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLL, 7 SRL, 8 SRA; shift amount is B[log2(DATAPATH_WIDTH)-1:0].
  - 9 SLT: signed A<B gives 1, else 0.
  - 10 PASSB: result is B.
  - 11 MUL: low `DATAPATH_WIDTH` bits of unsigned A*B.
  - 12-15: result 0, controls passed through unchanged.
- Branch logic:
  - `taken = (beq_in & A==B) | (bneq_in & A!=B)`.
  - If `beq_in` and `bneq_in` are both 1, the branch is always taken.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if `alu_ctrl_in`==MUL, latch A and B, clear the accumulator and iteration count, and go to BUSY. This does not depend on `en`.
  - BUSY: each cycle adds `B_chunk*A<<shift` for one `MUL_BITS_PER_CYCLE` slice. After `DATAPATH_WIDTH/MUL_BITS_PER_CYCLE` iterations (16 by default), go to DONE. BUSY ignores `en`.
  - DONE: stays in DONE until `en`=1. On that edge, register the product together with the held upstream controls, then return to IDLE.
- `stall_out` = (state==BUSY) | (state==IDLE & `alu_ctrl_in`==MUL).
- Output register on an edge with `en`=1:
  - If `stall_out`=1: load a bubble. `WR_en_out`, `mem_write_out`, `mem_reg_sel_out`, and `branch_taken_out` go to 0; other fields hold their previous values.
  - Otherwise: load the computed result and the pass-through fields.
- With `en`=0, all outputs hold.
- Reset values: every output register is 0, and the FSM is in IDLE.
  - `stall_out` therefore follows the IDLE rule combinationally.
  - Asserting reset during BUSY or DONE discards the partial product.

## Timing
- Non-MUL ops: inputs sampled on edge N with `en`=1 appear on the outputs after edge N. Latency is 1 and throughput is 1 per cycle.
- MUL presented in cycle 0, with default parameters:
  - `stall_out`=1 in cycles 0-16 (17 cycles).
  - Cycle 17 is DONE and `stall_out`=0.
  - The product is on the outputs from cycle 18, given `en`=1 in cycle 17.
  - Bubbles are emitted on every `en` edge from cycle 0 to cycle 16.
- Back-to-back MULs: the second MUL is seen in IDLE in cycle 18 and restarts the sequence with no extra gap.
- `en` low in DONE extends DONE. `stall_out` stays 0 in DONE, and upstream is already held by `en`.

## Structure
- Package `exec_pkg`: opcode localparams ALU_ADD through ALU_MUL, and FSM state encodings.
- Sub-module `iterative_multiplier`:
  - Contains the FSM, operand latches, accumulator and iteration counter.
  - Ports: `start`, `ack` (tied to `en`), `busy`, `done`, `product`.
- `execute_stage` contains the combinational ALU, the branch comparator, stall generation and the output register.

## Test plan
- Reset low mid-BUSY (cycle 5 of a MUL): all outputs 0 and FSM in IDLE immediately. After release, ADD 2+3 gives `alu_result_out`=5 one edge later.
- ADD/SUB/SLT/SRA sequence with `en`=1 every cycle:
  - 0xFFFF_FFFF_FFFF_FFFF + 1 gives 0.
  - 3 - 5 gives 0xFFFF_FFFF_FFFF_FFFE.
  - SLT(-1, 1) gives 1.
  - SRA(0x8000_0000_0000_0000, 4) gives 0xF800_0000_0000_0000.
  - Each result appears one cycle after its inputs.
- MUL 0x1_0000_0001 * 0x3 with `WR_addr_in`=7: `stall_out` high for exactly 17 cycles and 17 bubbles with `WR_en_out`=0. Then `alu_result_out`=0x3_0000_0003, `WR_addr_out`=7, `WR_en_out`=1.
- MUL with `en`=0 throughout cycles 15-20: FSM holds in DONE and outputs are unchanged. The first `en`=1 edge delivers the product.
- Branches with R1=R2=9:
  - beq: `branch_taken_out`=1 and `branch_offset_out`=`branch_offset_in`.
  - bneq: 0.
  - beq and bneq both set: 1.
  - `thread_id_out` matches `thread_id_in`.
- Opcode 13 with `WR_en_in`=1: `alu_result_out`=0, `WR_en_out`=1, `stall_out`=0.
